fft_bank_sched: RTL and testbench
=================================

FFT_BANK_SCHED -- requirements
Module: fft_bank_sched

Interface
REQ-001 SHALL have parameter BINS, default 256, FFT bins per frame (power of two, >=4).
REQ-002 SHALL have parameter MICS, default 8, BRAM words written per bin.
REQ-003 SHALL have parameter BANK_BYTES, default BINS*MICS*4 (8192), byte size of one BRAM bank.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_beat  in  1  one-cycle pulse: writer finished storing all MICS words of one bin.
REQ-007 SHALL have port wr_last  in  1  qualifies wr_beat: bin carried the FFT stream tlast.
REQ-008 SHALL have port wr_allow  out  1  writer may accept the next FFT beat (gates writer tready).
REQ-009 SHALL have port wr_base  out  32  byte base address of the bank being filled.
REQ-010 SHALL have port wr_bin  out  log2(BINS)  bin index expected on next wr_beat.
REQ-011 SHALL have port rd_valid  out  1  a completed bank is offered to the reader.
REQ-012 SHALL have port rd_ready  in  1  reader accepts the offered bank.
REQ-013 SHALL have port rd_base  out  32  byte base of offered/held bank.
REQ-014 SHALL have port rd_done  in  1  one-cycle pulse: reader releases its held bank.
REQ-015 SHALL have port frame_cnt  out  16  completed frames, wraps 0xFFFF->0.
REQ-016 SHALL have port drop_cnt  out  16  wr_beat pulses received while wr_allow=0, saturates at 0xFFFF.
REQ-017 SHALL have port frame_err  out  1  sticky: wr_last position disagreed with bin count.

Function
REQ-018 SHALL manage two banks (0 at base 0, 1 at base BANK_BYTES), each in state FREE, FILLING, READY or READING; at most one bank FILLING.
REQ-019 SHALL advance wr_bin by 1 on each wr_beat accepted while wr_allow=1.
REQ-020 SHALL complete a frame on accepted wr_beat with wr_bin=BINS-1: filling bank -> READY, frame_cnt+1, wr_bin -> 0.
REQ-021 SHALL, on completion, make the other bank FILLING and wr_allow=1 next cycle if it is FREE (including freed by rd_done that same cycle); otherwise wr_allow=0 and no bank FILLING.
REQ-022 SHALL, while stalled, switch to the first bank becoming FREE: that bank FILLING and wr_allow=1 the cycle after its rd_done.
REQ-023 SHALL treat wr_last with wr_bin!=BINS-1 as early end: set frame_err, wr_bin -> 0, same bank stays FILLING, frame_cnt unchanged.
REQ-024 SHALL treat wr_bin=BINS-1 without wr_last as completion per REQ-020 and set frame_err.
REQ-025 SHALL ignore wr_beat while wr_allow=0 except for incrementing drop_cnt.
REQ-026 SHALL assert rd_valid while any bank is READY and none is READING; with both READY, offer the older-completed bank.
REQ-027 SHALL, on rd_valid & rd_ready, move offered bank READY -> READING; rd_valid deasserts next cycle unless rule REQ-026 still holds after transition (it cannot; only one READING).
REQ-028 SHALL hold rd_base stable from rd_valid assertion through rd_done of that bank.
REQ-029 SHALL, on rd_done, move the READING bank to FREE; rd_done with no bank READING SHALL be ignored.
REQ-030 SHALL register all outputs; every state change visible the cycle after its cause.
REQ-031 SHALL drive wr_base = bank_index*BANK_BYTES, rd_base likewise, as 32-bit values.

Reset
REQ-032 SHALL, when rst=1 at a clock edge, set bank0 FILLING, bank1 FREE, wr_allow=1, wr_base=0, wr_bin=0, rd_valid=0, rd_base=0, frame_cnt=0, drop_cnt=0, frame_err=0.
REQ-033 SHALL abandon any in-progress frame or held read on rst; rst dominates all other inputs in the same cycle.

Verification
REQ-034 Bench SHALL run: 256 wr_beats, last with wr_last -> frame_cnt=1, rd_valid=1, rd_base=0, wr_base=8192, wr_allow stays 1.
REQ-035 Bench SHALL run: two full frames, no rd_ready -> after second completion wr_allow=0; 3 further wr_beats -> drop_cnt=3, wr_bin=0, frame_cnt=2.
REQ-036 Bench SHALL run: from REQ-035 state, rd_ready then rd_done on bank0 -> next cycle wr_allow=1, wr_base=0; rd_valid=1, rd_base=8192.
REQ-037 Bench SHALL run: wr_last on 10th beat (wr_bin=9) -> frame_err=1, wr_bin=0, frame_cnt=0, wr_base unchanged.
REQ-038 Bench SHALL run: frame completion same cycle as rd_done of other bank -> wr_allow never drops, wr_base switches next cycle.
REQ-039 Bench SHALL run: rst asserted mid-frame (wr_bin=100) with bank1 READING -> all outputs at REQ-032 values next cycle.

Source files
------------

// File: rtl/fft_bank_sched.sv
// ----------------------------------------------------------------------------
// fft_bank_sched
// Ping-pong scheduler for two BRAM banks that hold FFT frames. A writer stores
// one bin (MICS words) per wr_beat_i into the bank being filled. A reader takes
// completed banks through a valid/ready offer and returns each one with a
// rd_done_i pulse. Every output comes straight from a register, so each state
// change shows up on the cycle after the event that caused it.
//
// Ports
//   clk_i        in   clock; all logic on the rising edge
//   rst_i        in   synchronous active-high reset; overrides all other inputs
//   wr_beat_i    in   pulse: writer finished one bin
//   wr_last_i    in   qualifies wr_beat_i: that bin carried the stream tlast
//   wr_allow_o   out  writer may accept the next FFT beat
//   wr_base_o    out  byte base of the bank being filled
//   wr_bin_o     out  bin index expected on the next wr_beat_i
//   rd_valid_o   out  a completed bank is offered to the reader
//   rd_ready_i   in   reader accepts the offered bank
//   rd_base_o    out  byte base of the offered or held bank
//   rd_done_i    in   pulse: reader releases its held bank
//   frame_cnt_o  out  completed frames, wraps
//   drop_cnt_o   out  beats received while wr_allow_o=0, saturates
//   frame_err_o  out  sticky: wr_last_i disagreed with the bin count
//
// Bank states
//   BANK_FREE    | empty, may be chosen for filling
//   BANK_FILLING | writer is storing bins into it (at most one bank)
//   BANK_READY   | holds a complete frame waiting for the reader
//   BANK_READING | handed to the reader, awaiting rd_done_i
// ----------------------------------------------------------------------------
module fft_bank_sched #(
    parameter int BINS       = 256,
    parameter int MICS       = 8,
    parameter int BANK_BYTES = BINS * MICS * 4,
    localparam int BIN_W     = $clog2(BINS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_beat_i,
    input  logic             wr_last_i,
    output logic             wr_allow_o,
    output logic [31:0]      wr_base_o,
    output logic [BIN_W-1:0] wr_bin_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [31:0]      rd_base_o,
    input  logic             rd_done_i,
    output logic [15:0]      frame_cnt_o,
    output logic [15:0]      drop_cnt_o,
    output logic             frame_err_o
);

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_READY,
        BANK_READING
    } bank_state_e;

    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    logic [BIN_W-1:0] wr_bin_q, wr_bin_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             frame_err_q, frame_err_d;
    logic             wr_allow_q, wr_allow_d;
    logic [31:0]      wr_base_q, wr_base_d;
    logic             rd_valid_q, rd_valid_d;
    logic [31:0]      rd_base_q, rd_base_d;
    logic             wr_sel_q, wr_sel_d;   // index of the filling bank
    logic             rd_sel_q, rd_sel_d;   // index of the offered/held bank
    logic             older_q, older_d;     // earlier-completed bank when both READY

    logic accept;
    logic last_bin;
    logic freed;
    logic freed_idx;
    logic any_ready;
    logic any_reading;
    logic both_ready;

    function automatic logic [31:0] base_of(input logic idx);
        return idx ? 32'(BANK_BYTES) : 32'd0;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_q[0]   <= BANK_FILLING;
            bank_q[1]   <= BANK_FREE;
            wr_bin_q    <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            frame_err_q <= 1'b0;
            wr_allow_q  <= 1'b1;
            wr_base_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_base_q   <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            older_q     <= 1'b0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            wr_bin_q    <= wr_bin_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            frame_err_q <= frame_err_d;
            wr_allow_q  <= wr_allow_d;
            wr_base_q   <= wr_base_d;
            rd_valid_q  <= rd_valid_d;
            rd_base_q   <= rd_base_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            older_q     <= older_d;
        end
    end

    always_comb begin
        bank_d[0]   = bank_q[0];
        bank_d[1]   = bank_q[1];
        wr_bin_d    = wr_bin_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        frame_err_d = frame_err_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        older_d     = older_q;
        freed       = 1'b0;
        freed_idx   = 1'b0;

        accept   = wr_beat_i & wr_allow_q;
        last_bin = (wr_bin_q == BIN_W'(BINS - 1));

        // Reader release first, so a bank freed this cycle can be refilled
        // by a completion or a stalled writer in the same cycle.
        if (rd_done_i) begin
            if (bank_q[0] == BANK_READING) begin
                bank_d[0] = BANK_FREE;
                freed     = 1'b1;
                freed_idx = 1'b0;
            end else if (bank_q[1] == BANK_READING) begin
                bank_d[1] = BANK_FREE;
                freed     = 1'b1;
                freed_idx = 1'b1;
            end
        end

        // An offer only exists while nothing is READING, so this never
        // collides with the release above.
        if (rd_valid_q && rd_ready_i) begin
            bank_d[rd_sel_q] = BANK_READING;
        end

        if (accept) begin
            if (last_bin) begin
                bank_d[wr_sel_q] = BANK_READY;
                frame_cnt_d      = frame_cnt_q + 16'd1;
                wr_bin_d         = '0;
                if (!wr_last_i) begin
                    frame_err_d = 1'b1;
                end
                if (bank_d[~wr_sel_q] != BANK_READY) begin
                    older_d = wr_sel_q;
                end
                if (bank_d[~wr_sel_q] == BANK_FREE) begin
                    bank_d[~wr_sel_q] = BANK_FILLING;
                    wr_sel_d          = ~wr_sel_q;
                end
            end else if (wr_last_i) begin
                // Early tlast: restart the frame in the same bank.
                frame_err_d = 1'b1;
                wr_bin_d    = '0;
            end else begin
                wr_bin_d = wr_bin_q + 1'b1;
            end
        end else if (wr_beat_i && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        if (!wr_allow_q && freed) begin
            bank_d[freed_idx] = BANK_FILLING;
            wr_sel_d          = freed_idx;
        end

        wr_allow_d  = (bank_d[0] == BANK_FILLING) || (bank_d[1] == BANK_FILLING);
        wr_base_d   = wr_allow_d ? base_of(wr_sel_d) : wr_base_q;

        any_ready   = (bank_d[0] == BANK_READY) || (bank_d[1] == BANK_READY);
        both_ready  = (bank_d[0] == BANK_READY) && (bank_d[1] == BANK_READY);
        any_reading = (bank_d[0] == BANK_READING) || (bank_d[1] == BANK_READING);
        rd_valid_d  = any_ready && !any_reading;

        // A newly completed bank is always younger than one already offered,
        // so the selection below never moves while an offer is pending.
        if (rd_valid_d) begin
            rd_sel_d = both_ready ? older_d : (bank_d[1] == BANK_READY);
        end else if (any_reading) begin
            rd_sel_d = (bank_d[1] == BANK_READING);
        end
        rd_base_d = base_of(rd_sel_d);
    end

    assign wr_allow_o  = wr_allow_q;
    assign wr_base_o   = wr_base_q;
    assign wr_bin_o    = wr_bin_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_base_o   = rd_base_q;
    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_fft_bank_sched.sv
module tb_fft_bank_sched;

    localparam int BINS  = 256;
    localparam int BB    = 8192;
    localparam int BIN_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             wr_beat_i = 1'b0;
    logic             wr_last_i = 1'b0;
    logic             rd_ready_i = 1'b0;
    logic             rd_done_i = 1'b0;
    logic             wr_allow_o;
    logic [31:0]      wr_base_o;
    logic [BIN_W-1:0] wr_bin_o;
    logic             rd_valid_o;
    logic [31:0]      rd_base_o;
    logic [15:0]      frame_cnt_o;
    logic [15:0]      drop_cnt_o;
    logic             frame_err_o;

    int checks = 0;
    int errors = 0;

    fft_bank_sched #(.BINS(BINS), .MICS(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_beat_i(wr_beat_i), .wr_last_i(wr_last_i),
        .wr_allow_o(wr_allow_o), .wr_base_o(wr_base_o), .wr_bin_o(wr_bin_o),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_base_o(rd_base_o),
        .rd_done_i(rd_done_i),
        .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o), .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: banks tracked as "which one fills", "which one the
    // reader holds" and a completion-order queue of finished banks.
    int          m_fill, m_read, m_bin, m_fc, m_dc;
    bit          m_err, m_allow, m_rvalid;
    int          m_rdq[$];
    logic [31:0] m_wbase, m_rbase;

    function automatic bit m_is_free(int b);
        if (b == m_fill || b == m_read) return 1'b0;
        foreach (m_rdq[i]) if (m_rdq[i] == b) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit b, input bit l,
                              input bit rdy, input bit d);
        int freed = -1;
        int fill_before;
        if (r) begin
            m_fill = 0; m_read = -1; m_rdq.delete(); m_bin = 0;
            m_fc = 0; m_dc = 0; m_err = 0; m_wbase = 0; m_rbase = 0;
        end else begin
            fill_before = m_fill;
            if (d && m_read >= 0) begin
                freed  = m_read;
                m_read = -1;
            end
            if (m_rvalid && rdy) m_read = m_rdq.pop_front();
            if (b) begin
                if (m_allow) begin
                    if (m_bin == BINS - 1) begin
                        m_rdq.push_back(m_fill);
                        m_fc = (m_fc + 1) % 65536;
                        if (!l) m_err = 1;
                        m_bin = 0;
                        m_fill = m_is_free(1 - m_fill) ? 1 - m_fill : -1;
                    end else if (l) begin
                        m_err = 1;
                        m_bin = 0;
                    end else begin
                        m_bin++;
                    end
                end else if (m_dc < 65535) begin
                    m_dc++;
                end
            end
            if (fill_before < 0 && freed >= 0) m_fill = freed;
        end
        m_allow  = (m_fill >= 0);
        if (m_allow) m_wbase = 32'(m_fill * BB);
        m_rvalid = (m_rdq.size() > 0) && (m_read < 0);
        if (m_rvalid) m_rbase = 32'(m_rdq[0] * BB);
        else if (m_read >= 0) m_rbase = 32'(m_read * BB);
    endtask

    task automatic cycle(input bit r, input bit b, input bit l,
                         input bit rdy, input bit d);
        rst_i = r; wr_beat_i = b; wr_last_i = l; rd_ready_i = rdy; rd_done_i = d;
        @(posedge clk_i);
        model_step(r, b, l, rdy, d);
        @(negedge clk_i);
        rst_i = 0; wr_beat_i = 0; wr_last_i = 0; rd_ready_i = 0; rd_done_i = 0;
    endtask

    task automatic beats(input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) cycle(0, 1, last_on_final && (i == n - 1), 0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        checks++; if (wr_allow_o !== 1'b1) begin errors++; $display("FAIL reset_allow got %0d want 1", wr_allow_o); end
        checks++; if (wr_base_o !== 32'd0) begin errors++; $display("FAIL reset_wbase got %0d want 0", wr_base_o); end
        checks++; if (wr_bin_o !== 8'd0) begin errors++; $display("FAIL reset_bin got %0d want 0", wr_bin_o); end
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0d want 0", rd_valid_o); end
        checks++; if (rd_base_o !== 32'd0) begin errors++; $display("FAIL reset_rbase got %0d want 0", rd_base_o); end
        checks++; if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt_o); end
        checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_dcnt got %0d want 0", drop_cnt_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0d want 0", frame_err_o); end
    endtask

    task automatic test_single_frame();
        bit dropped = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < BINS; i++) begin
            cycle(0, 1, i == BINS - 1, 0, 0);
            if (wr_allow_o !== 1'b1) dropped = 1;
        end
        checks++; if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL one_fcnt got %0d want 1", frame_cnt_o); end
        checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL one_rvalid got %0d want 1", rd_valid_o); end
        checks++; if (rd_base_o !== 32'd0) begin errors++; $display("FAIL one_rbase got %0d want 0", rd_base_o); end
        checks++; if (wr_base_o !== 32'd8192) begin errors++; $display("FAIL one_wbase got %0d want 8192", wr_base_o); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL one_allow_held got dropped=%0d want 0", dropped); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL one_ferr got %0d want 0", frame_err_o); end
    endtask

    task automatic test_stall();
        cycle(1, 0, 0, 0, 0);
        beats(BINS, 1);
        beats(BINS, 1);
        checks++; if (wr_allow_o !== 1'b0) begin errors++; $display("FAIL stall_allow got %0d want 0", wr_allow_o); end
        beats(3, 0);
        checks++; if (drop_cnt_o !== 16'd3) begin errors++; $display("FAIL stall_dcnt got %0d want 3", drop_cnt_o); end
        checks++; if (wr_bin_o !== 8'd0) begin errors++; $display("FAIL stall_bin got %0d want 0", wr_bin_o); end
        checks++; if (frame_cnt_o !== 16'd2) begin errors++; $display("FAIL stall_fcnt got %0d want 2", frame_cnt_o); end
        checks++; if (rd_base_o !== 32'd0) begin errors++; $display("FAIL stall_older got %0d want 0", rd_base_o); end
    endtask

    task automatic test_release();
        cycle(0, 0, 0, 1, 0);
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL rel_rvalid_drop got %0d want 0", rd_valid_o); end
        cycle(0, 0, 0, 0, 0);
        checks++; if (rd_base_o !== 32'd0) begin errors++; $display("FAIL rel_rbase_hold got %0d want 0", rd_base_o); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (wr_allow_o !== 1'b1) begin errors++; $display("FAIL rel_allow got %0d want 1", wr_allow_o); end
        checks++; if (wr_base_o !== 32'd0) begin errors++; $display("FAIL rel_wbase got %0d want 0", wr_base_o); end
        checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL rel_rvalid got %0d want 1", rd_valid_o); end
        checks++; if (rd_base_o !== 32'd8192) begin errors++; $display("FAIL rel_rbase got %0d want 8192", rd_base_o); end
    endtask

    task automatic test_early_last();
        cycle(1, 0, 0, 0, 0);
        beats(10, 1);
        checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL early_ferr got %0d want 1", frame_err_o); end
        checks++; if (wr_bin_o !== 8'd0) begin errors++; $display("FAIL early_bin got %0d want 0", wr_bin_o); end
        checks++; if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL early_fcnt got %0d want 0", frame_cnt_o); end
        checks++; if (wr_base_o !== 32'd0) begin errors++; $display("FAIL early_wbase got %0d want 0", wr_base_o); end
        // A full frame without tlast still completes but flags the error.
        cycle(1, 0, 0, 0, 0);
        beats(BINS, 0);
        checks++; if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL notlast_fcnt got %0d want 1", frame_cnt_o); end
        checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL notlast_ferr got %0d want 1", frame_err_o); end
    endtask

    task automatic test_back_to_back();
        bit dropped = 0;
        cycle(1, 0, 0, 0, 0);
        beats(BINS, 1);
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < BINS; i++) begin
            cycle(0, 1, i == BINS - 1, 0, i == BINS - 1);
            if (wr_allow_o !== 1'b1) dropped = 1;
        end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL b2b_allow_held got dropped=%0d want 0", dropped); end
        checks++; if (wr_base_o !== 32'd0) begin errors++; $display("FAIL b2b_wbase got %0d want 0", wr_base_o); end
        checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_rvalid got %0d want 1", rd_valid_o); end
        checks++; if (rd_base_o !== 32'd8192) begin errors++; $display("FAIL b2b_rbase got %0d want 8192", rd_base_o); end
        checks++; if (frame_cnt_o !== 16'd2) begin errors++; $display("FAIL b2b_fcnt got %0d want 2", frame_cnt_o); end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0, 0);
        beats(BINS, 1);
        beats(BINS, 1);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0);
        beats(100, 0);
        checks++; if (wr_bin_o !== 8'd100) begin errors++; $display("FAIL mid_pre_bin got %0d want 100", wr_bin_o); end
        checks++; if (rd_base_o !== 32'd8192) begin errors++; $display("FAIL mid_pre_rbase got %0d want 8192", rd_base_o); end
        cycle(1, 1, 1, 1, 1);
        checks++; if (wr_allow_o !== 1'b1) begin errors++; $display("FAIL mid_allow got %0d want 1", wr_allow_o); end
        checks++; if (wr_base_o !== 32'd0) begin errors++; $display("FAIL mid_wbase got %0d want 0", wr_base_o); end
        checks++; if (wr_bin_o !== 8'd0) begin errors++; $display("FAIL mid_bin got %0d want 0", wr_bin_o); end
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %0d want 0", rd_valid_o); end
        checks++; if (rd_base_o !== 32'd0) begin errors++; $display("FAIL mid_rbase got %0d want 0", rd_base_o); end
        checks++; if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_fcnt got %0d want 0", frame_cnt_o); end
        checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_dcnt got %0d want 0", drop_cnt_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL mid_ferr got %0d want 0", frame_err_o); end
    endtask

    task automatic test_random();
        int shown = 0;
        bit b, l, rdy, d, r;
        cycle(1, 0, 0, 0, 0);
        for (int n = 0; n < 12000; n++) begin
            r   = ($urandom_range(0, 4999) == 0);
            b   = ($urandom_range(0, 3) != 0);
            l   = (m_bin == BINS - 1) ? ($urandom_range(0, 9) != 0)
                                      : ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            d   = ($urandom_range(0, 3) == 0);
            cycle(r, b, l, rdy, d);
            checks++;
            if (wr_allow_o !== m_allow || wr_base_o !== m_wbase || wr_bin_o !== 8'(m_bin) ||
                rd_valid_o !== m_rvalid || rd_base_o !== m_rbase ||
                frame_cnt_o !== 16'(m_fc) || drop_cnt_o !== 16'(m_dc) || frame_err_o !== m_err) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL rand_cycle%0d got allow=%0d wbase=%0d bin=%0d rv=%0d rbase=%0d fc=%0d dc=%0d err=%0d want allow=%0d wbase=%0d bin=%0d rv=%0d rbase=%0d fc=%0d dc=%0d err=%0d",
                             n, wr_allow_o, wr_base_o, wr_bin_o, rd_valid_o, rd_base_o, frame_cnt_o, drop_cnt_o, frame_err_o,
                             m_allow, m_wbase, m_bin, m_rvalid, m_rbase, m_fc, m_dc, m_err);
                end
            end
        end
    endtask

    initial begin
        m_fill = 0; m_read = -1; m_bin = 0; m_fc = 0; m_dc = 0;
        m_err = 0; m_allow = 1; m_rvalid = 0; m_wbase = 0; m_rbase = 0;
        @(negedge clk_i);
        test_reset();
        test_single_frame();
        test_stall();
        test_release();
        test_early_last();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
